ahb_bram_ctrl: RTL and testbench

AHB_BRAM_CTRL -- requirements
Module: ahb_bram_ctrl

---
 rtl/ahb_bram_pkg.sv | 34 +++
 rtl/ahb_bram_if.sv | 26 ++
 rtl/ahb_bram_strb.sv | 29 ++
 rtl/ahb_bram_ctrl.sv | 116 +++++++++++
 tb/tb_ahb_bram_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_bram_pkg.sv
// Shared AHB-Lite encodings and helpers for the BRAM controller.
// Imported by the strobe decoder, the controller top and the bench.
package ahb_bram_pkg;

   typedef enum logic [1:0] {
      HT_IDLE   = 2'd0,
      HT_BUSY   = 2'd1,
      HT_NONSEQ = 2'd2,
      HT_SEQ    = 2'd3
   } htrans_e;

   localparam logic [2:0] SZ_BYTE = 3'd0;
   localparam logic [2:0] SZ_HALF = 3'd1;
   localparam logic [2:0] SZ_WORD = 3'd2;

   typedef enum logic [1:0] {
      ST_OKAY = 2'd0,
      ST_ERR1 = 2'd1,
      ST_ERR2 = 2'd2
   } resp_st_e;

   function automatic logic [31:0] byte_merge(
      input logic [31:0] old_w,
      input logic [31:0] new_w,
      input logic [3:0]  strb
   );
      logic [31:0] res;
      for (int i = 0; i < 4; i++)
         res[8*i +: 8] = strb[i] ? new_w[8*i +: 8]
                                 : old_w[8*i +: 8];
      return res;
   endfunction

endpackage

// File: rtl/ahb_bram_if.sv
// AHB-Lite slave-side bus bundle for the BRAM controller.
// The master modport drives control; the slave modport answers.
interface ahb_bram_if;

   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic        hwrite;
   logic        hready;
   logic [31:0] hwdata;
   logic        hreadyout;
   logic        hresp;
   logic [31:0] hrdata;

   modport master (
      output hsel, haddr, htrans, hsize, hwrite, hwdata,
      input  hready, hreadyout, hresp, hrdata
   );

   modport slave (
      input  hsel, haddr, htrans, hsize, hwrite, hwdata, hready,
      output hreadyout, hresp, hrdata
   );

endinterface

// File: rtl/ahb_bram_strb.sv
// Size/alignment decode: byte strobes plus an error for
// unsupported sizes and misaligned halfword/word transfers.
module ahb_bram_strb
   import ahb_bram_pkg::*;
(
   input  logic [1:0] addr,
   input  logic [2:0] size,
   output logic [3:0] strb,
   output logic       err
);

   always_comb begin
      strb = '0;
      err  = 1'b0;
      unique case (1'b1)
         (size == SZ_BYTE): strb = 4'b0001 << addr;
         (size == SZ_HALF): begin
            strb = addr[1] ? 4'b1100 : 4'b0011;
            err  = addr[0];
         end
         (size == SZ_WORD): begin
            strb = 4'b1111;
            err  = |addr;
         end
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite slave bridging to an external dual-port block RAM,
// zero-wait reads, write forwarding and a two-cycle ERROR response.
module ahb_bram_ctrl
   import ahb_bram_pkg::*;
#(
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  HSEL,
   input  logic [31:0]           HADDR,
   input  logic [1:0]            HTRANS,
   input  logic [2:0]            HSIZE,
   input  logic                  HWRITE,
   input  logic                  HREADY,
   input  logic [31:0]           HWDATA,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic [31:0]           HRDATA,
   output logic [ADDR_WIDTH-1:0] addra,
   output logic [31:0]           dina,
   output logic [3:0]            wea,
   output logic [ADDR_WIDTH-1:0] addrb,
   input  logic [31:0]           doutb
);

   localparam int AW = ADDR_WIDTH;

   logic          acc;
   logic          err;
   logic [3:0]    strb;
   logic [AW-1:0] haddr_w;

   resp_st_e      state_q, state_d;
   logic          wr_pend_q, wr_pend_d;
   logic [AW-1:0] waddr_q, waddr_d;
   logic [3:0]    wstrb_q, wstrb_d;
   logic          hazard_q, hazard_d;
   logic [31:0]   fwd_data_q, fwd_data_d;
   logic [3:0]    fwd_strb_q, fwd_strb_d;

   logic unused_haddr;
   assign unused_haddr = ^HADDR[31:AW+2];

   ahb_bram_strb u_strb (
      .addr (HADDR[1:0]),
      .size (HSIZE),
      .strb (strb),
      .err  (err)
   );

   assign haddr_w = HADDR[AW+1:2];
   assign acc     = HSEL & HREADY & HTRANS[1];

   always_comb begin
      wr_pend_d  = acc & HWRITE & ~err;
      waddr_d    = acc ? haddr_w : waddr_q;
      wstrb_d    = acc ? strb : wstrb_q;
      // RAM returns old data on a same-word collision, so keep the
      // in-flight write to patch the read in the following cycle.
      hazard_d   = acc & ~HWRITE & ~err & wr_pend_q
                 & (waddr_q == haddr_w);
      fwd_data_d = HWDATA;
      fwd_strb_d = wstrb_q;
   end

   always_comb begin
      state_d   = state_q;
      HREADYOUT = 1'b1;
      HRESP     = 1'b0;
      unique case (state_q)
         ST_OKAY: begin
            if (acc && err) state_d = ST_ERR1;
         end
         ST_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = 1'b1;
            state_d   = ST_ERR2;
         end
         ST_ERR2: begin
            HRESP   = 1'b1;
            state_d = (acc && err) ? ST_ERR1 : ST_OKAY;
         end
         default: state_d = ST_OKAY;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q    <= ST_OKAY;
         wr_pend_q  <= 1'b0;
         waddr_q    <= '0;
         wstrb_q    <= '0;
         hazard_q   <= 1'b0;
         fwd_data_q <= '0;
         fwd_strb_q <= '0;
      end else begin
         state_q    <= state_d;
         wr_pend_q  <= wr_pend_d;
         waddr_q    <= waddr_d;
         wstrb_q    <= wstrb_d;
         hazard_q   <= hazard_d;
         fwd_data_q <= fwd_data_d;
         fwd_strb_q <= fwd_strb_d;
      end
   end

   // Reset during a data phase drops the write before the RAM edge.
   assign wea    = (wr_pend_q & ~HRESET) ? wstrb_q : 4'b0000;
   assign addra  = waddr_q;
   assign dina   = HWDATA;
   assign addrb  = haddr_w;
   assign HRDATA = hazard_q ? byte_merge(doutb, fwd_data_q, fwd_strb_q)
                            : doutb;

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Directed bench: vector table plus reset sequences, with a
// behavioural 1-cycle, read-old-data dual-port RAM model.
module tb_ahb_bram_ctrl;
   import ahb_bram_pkg::*;

   localparam int AW = 12;
   localparam logic [1:0] ID = 2'd0;
   localparam logic [1:0] BS = 2'd1;
   localparam logic [1:0] NS = 2'd2;
   localparam logic [1:0] SQ = 2'd3;
   localparam logic [2:0] B = 3'd0;
   localparam logic [2:0] H = 3'd1;
   localparam logic [2:0] W = 3'd2;
   localparam logic [2:0] D = 3'd3;

   typedef struct {
      logic        rst;
      logic        sel;
      logic [1:0]  trans;
      logic [2:0]  size;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        rdy;
      logic        resp;
      logic [3:0]  wea;
      logic [11:0] addra;
      logic        chk;
      logic [31:0] rdata;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ram_load = 1'b0;
   logic [AW-1:0] addra, addrb;
   logic [31:0]   dina, doutb;
   logic [3:0]    wea;
   logic [31:0]   mem [0:(1<<AW)-1];

   int n_chk  = 0;
   int n_fail = 0;
   int vidx   = 0;
   vec_t vq[$];

   ahb_bram_if bus ();
   assign bus.hready = bus.hreadyout;

   always #5 clk = ~clk;

   ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
      .HCLK      (clk),
      .HRESET    (rst),
      .HSEL      (bus.hsel),
      .HADDR     (bus.haddr),
      .HTRANS    (bus.htrans),
      .HSIZE     (bus.hsize),
      .HWRITE    (bus.hwrite),
      .HREADY    (bus.hready),
      .HWDATA    (bus.hwdata),
      .HREADYOUT (bus.hreadyout),
      .HRESP     (bus.hresp),
      .HRDATA    (bus.hrdata),
      .addra     (addra),
      .dina      (dina),
      .wea       (wea),
      .addrb     (addrb),
      .doutb     (doutb)
   );

   always @(posedge clk) begin
      if (ram_load) begin
         for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'h0;
         mem[1]  <= 32'hCAFEF00D;
         mem[8]  <= 32'h11223344;
         mem[16] <= 32'hAAAABBBB;
         doutb   <= 32'h0;
      end else begin
         for (int i = 0; i < 4; i++)
            if (wea[i]) mem[addra][8*i +: 8] <= dina[8*i +: 8];
         doutb <= mem[addrb];
      end
   end

   function automatic vec_t mk(
      input logic rs, input logic sl, input logic [1:0] tr,
      input logic [2:0] sz, input logic w,
      input logic [31:0] a, input logic [31:0] wd,
      input logic rd, input logic rp, input logic [3:0] we,
      input logic [11:0] aa, input logic ck,
      input logic [31:0] rdat
   );
      vec_t v;
      v.rst = rs; v.sel = sl; v.trans = tr; v.size = sz;
      v.wr = w; v.addr = a; v.wdata = wd;
      v.rdy = rd; v.resp = rp; v.wea = we; v.addra = aa;
      v.chk = ck; v.rdata = rdat;
      return v;
   endfunction

   task automatic cmp(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s vec %0d: got %h want %h",
                  nm, vidx, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      @(posedge clk);
      #1;
      rst        = v.rst;
      bus.hsel   = v.sel;
      bus.htrans = v.trans;
      bus.hsize  = v.size;
      bus.hwrite = v.wr;
      bus.haddr  = v.addr;
      bus.hwdata = v.wdata;
      @(negedge clk);
      cmp("hreadyout", {31'h0, bus.hreadyout}, {31'h0, v.rdy});
      cmp("hresp", {31'h0, bus.hresp}, {31'h0, v.resp});
      cmp("wea", {28'h0, wea}, {28'h0, v.wea});
      cmp("addrb", {20'h0, addrb}, {20'h0, v.addr[13:2]});
      if (v.wea != 4'h0)
         cmp("addra", {20'h0, addra}, {20'h0, v.addra});
      if (v.chk)
         cmp("hrdata", bus.hrdata, v.rdata);
      vidx++;
   endtask

   initial begin
      bus.hsel = 0; bus.htrans = ID; bus.hsize = W;
      bus.hwrite = 0; bus.haddr = 0; bus.hwdata = 0;
      ram_load = 1'b1;
      @(posedge clk);
      #1 ram_load = 1'b0;

      // reset state
      vq.push_back(mk(1,0,ID,W,0,'h0,0,   1,0,4'h0,0,0,0));
      vq.push_back(mk(1,1,NS,W,1,'h10,0,  1,0,4'h0,0,0,0));
      // word write then read two cycles later
      vq.push_back(mk(0,1,NS,W,1,'h10,0,  1,0,4'h0,0,0,0));
      vq.push_back(mk(0,0,ID,W,0,'h0,'h12345678,
                      1,0,4'hF,12'd4,0,0));
      vq.push_back(mk(0,1,NS,W,0,'h10,0,  1,0,4'h0,0,0,0));
      vq.push_back(mk(0,0,ID,W,0,'h0,0,
                      1,0,4'h0,0,1,'h12345678));
      // byte write into preloaded word
      vq.push_back(mk(0,1,NS,B,1,'h21,0,  1,0,4'h0,0,0,0));
      vq.push_back(mk(0,0,ID,W,0,'h0,'h0000AB00,
                      1,0,4'h2,12'd8,0,0));
      vq.push_back(mk(0,1,NS,W,0,'h20,0,  1,0,4'h0,0,0,0));
      vq.push_back(mk(0,0,ID,W,0,'h0,0,
                      1,0,4'h0,0,1,'h1122AB44));
      // halfword write, read of same word in its data phase
      vq.push_back(mk(0,1,NS,H,1,'h42,0,  1,0,4'h0,0,0,0));
      vq.push_back(mk(0,1,NS,W,0,'h40,'h55660000,
                      1,0,4'hC,12'd16,0,0));
      vq.push_back(mk(0,0,ID,W,0,'h0,0,
                      1,0,4'h0,0,1,'h5566BBBB));
      vq.push_back(mk(0,1,NS,W,0,'h40,0,  1,0,4'h0,0,0,0));
      vq.push_back(mk(0,0,ID,W,0,'h0,0,
                      1,0,4'h0,0,1,'h5566BBBB));
      // misaligned word write
      vq.push_back(mk(0,1,NS,W,1,'h06,0,  1,0,4'h0,0,0,0));
      vq.push_back(mk(0,0,ID,W,0,'h0,'hDEADBEEF,
                      0,1,4'h0,0,0,0));
      vq.push_back(mk(0,0,ID,W,0,'h0,0,   1,1,4'h0,0,0,0));
      vq.push_back(mk(0,0,ID,W,0,'h0,0,   1,0,4'h0,0,0,0));
      vq.push_back(mk(0,1,NS,W,0,'h04,0,  1,0,4'h0,0,0,0));
      vq.push_back(mk(0,0,ID,W,0,'h0,0,
                      1,0,4'h0,0,1,'hCAFEF00D));
      // HSIZE=3, repeated in ERR2
      vq.push_back(mk(0,1,NS,D,0,'h0,0,   1,0,4'h0,0,0,0));
      vq.push_back(mk(0,0,ID,W,0,'h0,0,   0,1,4'h0,0,0,0));
      vq.push_back(mk(0,1,NS,D,0,'h0,0,   1,1,4'h0,0,0,0));
      vq.push_back(mk(0,0,ID,W,0,'h0,0,   0,1,4'h0,0,0,0));
      vq.push_back(mk(0,0,ID,W,0,'h0,0,   1,1,4'h0,0,0,0));
      vq.push_back(mk(0,0,ID,W,0,'h0,0,   1,0,4'h0,0,0,0));
      // odd halfword write
      vq.push_back(mk(0,1,NS,H,1,'h21,0,  1,0,4'h0,0,0,0));
      vq.push_back(mk(0,0,ID,W,0,'h0,'hFFFFFFFF,
                      0,1,4'h0,0,0,0));
      vq.push_back(mk(0,0,ID,W,0,'h0,0,   1,1,4'h0,0,0,0));
      // deselected and BUSY writes are ignored
      vq.push_back(mk(0,0,NS,W,1,'h10,0,  1,0,4'h0,0,0,0));
      vq.push_back(mk(0,1,BS,W,1,'h10,'hFFFFFFFF,
                      1,0,4'h0,0,0,0));
      vq.push_back(mk(0,0,ID,W,0,'h10,'hFFFFFFFF,
                      1,0,4'h0,0,0,0));
      vq.push_back(mk(0,1,NS,W,0,'h10,'hFFFFFFFF,
                      1,0,4'h0,0,0,0));
      vq.push_back(mk(0,0,ID,W,0,'h0,0,
                      1,0,4'h0,0,1,'h12345678));
      // back-to-back byte writes
      vq.push_back(mk(0,1,NS,B,1,'h30,0,  1,0,4'h0,0,0,0));
      vq.push_back(mk(0,1,SQ,B,1,'h31,'h000000A1,
                      1,0,4'h1,12'd12,0,0));
      vq.push_back(mk(0,1,SQ,B,1,'h32,'h0000B200,
                      1,0,4'h2,12'd12,0,0));
      vq.push_back(mk(0,0,ID,W,0,'h0,'h00C30000,
                      1,0,4'h4,12'd12,0,0));
      vq.push_back(mk(0,1,NS,W,0,'h30,0,  1,0,4'h0,0,0,0));
      vq.push_back(mk(0,0,ID,W,0,'h0,0,
                      1,0,4'h0,0,1,'h00C3B2A1));

      foreach (vq[i]) apply(vq[i]);

      // reset in a write data phase
      apply(mk(0,1,NS,W,1,'h20,0,  1,0,4'h0,0,0,0));
      apply(mk(1,0,ID,W,0,'h0,'hFFFFFFFF,
               1,0,4'h0,0,0,0));
      apply(mk(0,0,ID,W,0,'h0,'hFFFFFFFF,
               1,0,4'h0,0,0,0));
      apply(mk(0,1,NS,W,0,'h20,0,  1,0,4'h0,0,0,0));
      apply(mk(0,0,ID,W,0,'h0,0,
               1,0,4'h0,0,1,'h1122AB44));

      // reset while in ERR1
      apply(mk(0,1,NS,W,1,'h06,0,  1,0,4'h0,0,0,0));
      apply(mk(1,0,ID,W,0,'h0,0,   0,1,4'h0,0,0,0));
      apply(mk(0,0,ID,W,0,'h0,0,   1,0,4'h0,0,0,0));
      apply(mk(0,0,ID,W,0,'h0,0,   1,0,4'h0,0,0,0));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
